// File: rtl/rr_mux8_pkg.sv
// Shared types and helpers for the round-robin 8-way mux arbiter.
package rr_mux8_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Captured word plus the requester that produced it.
    typedef struct packed {
        logic [SEL_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } out_word_t;

    function automatic logic [N_REQ-1:0] onehot3to8(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8x1.sv
// 32-bit 8:1 data mux shared by all requesters.
module mux8x1 (
    input  logic [31:0] A0,
    input  logic [31:0] A1,
    input  logic [31:0] A2,
    input  logic [31:0] A3,
    input  logic [31:0] A4,
    input  logic [31:0] A5,
    input  logic [31:0] A6,
    input  logic [31:0] A7,
    input  logic [2:0]  S,
    output logic [31:0] Y
);

    always_comb begin
        Y = A0;
        case (S)
            3'd0: Y = A0;
            3'd1: Y = A1;
            3'd2: Y = A2;
            3'd3: Y = A3;
            3'd4: Y = A4;
            3'd5: Y = A5;
            3'd6: Y = A6;
            3'd7: Y = A7;
            default: Y = A0;
        endcase
    end

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick8
    import rr_mux8_pkg::*;
(
    input  logic [N_REQ-1:0] eff_req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] winner
);

    logic [2*N_REQ-1:0] dbl_c;
    logic [N_REQ-1:0]   rot_c;
    logic [SEL_W-1:0]   idx_c;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        dbl_c = {eff_req, eff_req} >> ptr;
        rot_c = dbl_c[N_REQ-1:0];
        idx_c = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_c[i]) begin
                idx_c = SEL_W'(i);
            end
        end
        any    = |rot_c;
        winner = idx_c + ptr;
    end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sequencing a shared 8:1 mux; holds the winning word
// until the downstream consumer accepts it via valid/ready.
module rr_mux8_arbiter
    import rr_mux8_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_src,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             out_valid_q, out_valid_d;
    out_word_t        out_q, out_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic [N_REQ-1:0] eff_req_c;
    logic             pick_any_c;
    logic [SEL_W-1:0] pick_idx_c;
    logic [SEL_W-1:0] mux_sel_c;
    logic [31:0]      mux_y_c;

    // The requester acknowledged last cycle sits out one arbitration.
    assign eff_req_c = req & ~ack_q;
    assign mux_sel_c = (state_q == ST_IDLE) ? pick_idx_c : sel_q;

    rr_pick8 u_pick (
        .eff_req (eff_req_c),
        .ptr     (ptr_q),
        .any     (pick_any_c),
        .winner  (pick_idx_c)
    );

    mux8x1 u_mux (
        .A0 (d0),
        .A1 (d1),
        .A2 (d2),
        .A3 (d3),
        .A4 (d4),
        .A5 (d5),
        .A6 (d6),
        .A7 (d7),
        .S  (mux_sel_c),
        .Y  (mux_y_c)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        xfer_cnt_d  = xfer_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_c) begin
                    sel_d       = pick_idx_c;
                    gnt_d       = onehot3to8(pick_idx_c);
                    out_d.src   = pick_idx_c;
                    out_d.data  = mux_y_c;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    gnt_d       = '0;
                    ack_d       = onehot3to8(sel_q);
                    ptr_d       = sel_q + SEL_W'(1);
                    xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q.data;
    assign out_src   = out_q.src;
    assign busy      = out_valid_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule
